// File: rtl/vote_collector.sv
// Collects three serial one-bit votes tagged by voter id into a 3-bit word and
// offers it downstream over valid/ready; fills missing votes on timeout.
module vote_collector #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vote_valid,
  input  logic             vote_bit,
  input  logic [1:0]       vote_id,
  output logic             vote_ready,
  output logic [2:0]       word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             timeout_err,
  output logic             dup_err,
  output logic [CNT_W-1:0] round_cnt
);

  // Handshakes: a vote transfers on a cycle where vote_valid & vote_ready are
  // both high at the rising edge; a word transfers on word_valid & word_ready.
  // vote_ready depends only on registered state; word_* are all registered.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t           r_state;
  logic [2:0]       r_word;
  logic [2:0]       r_seen;
  logic [7:0]       r_timer;
  logic             r_word_valid;
  logic             r_timeout_err;
  logic             r_dup_err;
  logic [CNT_W-1:0] r_round_cnt;

  logic       w_accept;
  logic [2:0] w_id_mask;
  logic       w_legal;
  logic       w_new_vote;
  logic [2:0] w_seen_next;
  logic [2:0] w_word_next;
  logic       w_complete;
  logic       w_timeout;

  always_comb begin
    w_id_mask = 3'b000;
    case (vote_id)
      2'd0:    w_id_mask = 3'b001;
      2'd1:    w_id_mask = 3'b010;
      2'd2:    w_id_mask = 3'b100;
      default: w_id_mask = 3'b000;
    endcase
  end

  assign vote_ready  = (r_state != S_PRESENT);
  assign w_accept    = vote_valid & vote_ready;
  assign w_legal     = |w_id_mask;
  // A vote is only stored when its voter has not already voted this round.
  assign w_new_vote  = w_accept & w_legal & ~|(r_seen & w_id_mask);
  assign w_seen_next = w_new_vote ? (r_seen | w_id_mask) : r_seen;
  assign w_word_next = w_new_vote ? ((r_word & ~w_id_mask) | (vote_bit ? w_id_mask : 3'b000))
                                  : r_word;
  assign w_complete  = (w_seen_next == 3'b111);
  assign w_timeout   = (r_timer == TIMEOUT_L) && !w_complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_word        <= 3'b000;
      r_seen        <= 3'b000;
      r_timer       <= 8'd0;
      r_word_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_dup_err     <= 1'b0;
      r_round_cnt   <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      r_dup_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_word  <= vote_bit ? w_id_mask : 3'b000;
              r_seen  <= w_id_mask;
              r_timer <= 8'd1;
              r_state <= S_COLLECT;
            end else begin
              r_dup_err <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          r_timer <= r_timer + 8'd1;
          if (w_accept && !w_new_vote)
            r_dup_err <= 1'b1;
          // Masking with seen zeroes any voter that never arrived.
          r_word <= w_word_next & w_seen_next;
          r_seen <= w_seen_next;
          if (w_complete) begin
            r_word_valid <= 1'b1;
            r_state      <= S_PRESENT;
          end else if (w_timeout) begin
            r_word_valid  <= 1'b1;
            r_timeout_err <= 1'b1;
            r_state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (r_word_valid && word_ready) begin
            r_word_valid <= 1'b0;
            r_seen       <= 3'b000;
            r_timer      <= 8'd0;
            r_round_cnt  <= r_round_cnt + 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign word_out    = r_word;
  assign word_valid  = r_word_valid;
  assign timeout_err = r_timeout_err;
  assign dup_err     = r_dup_err;
  assign round_cnt   = r_round_cnt;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector: fixed vote sequences with hand-computed
// words, error pulses and round counts, plus a majority check on each word.
module tb_vote_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vote_valid = 1'b0;
  logic       vote_bit = 1'b0;
  logic [1:0] vote_id = 2'd0;
  logic       vote_ready;
  logic [2:0] word_out;
  logic       word_valid;
  logic       word_ready = 1'b1;
  logic       timeout_err;
  logic       dup_err;
  logic [7:0] round_cnt;

  int vectors = 0;
  int miscompares = 0;

  vote_collector #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .vote_valid(vote_valid), .vote_bit(vote_bit), .vote_id(vote_id),
    .vote_ready(vote_ready), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .timeout_err(timeout_err), .dup_err(dup_err),
    .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vote(input logic [1:0] id, input logic b);
    vote_valid = 1'b1;
    vote_id    = id;
    vote_bit   = b;
    tick();
    vote_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_word"}, {5'd0, word_out}, 8'h00);
    check({tag, "_wvalid"}, {7'd0, word_valid}, 8'h00);
    check({tag, "_vready"}, {7'd0, vote_ready}, 8'h01);
    check({tag, "_terr"}, {7'd0, timeout_err}, 8'h00);
    check({tag, "_derr"}, {7'd0, dup_err}, 8'h00);
    check({tag, "_cnt"}, round_cnt, 8'h00);
  endtask

  initial begin
    logic [2:0] pat;
    logic       exp_maj;
    logic       dut_maj;

    // Reset
    tick();
    tick();
    check_reset_state("rst");
    rst_n = 1'b1;
    tick();

    // Illegal id in IDLE: dropped, dup_err next cycle, still idle
    send_vote(2'd3, 1'b1);
    check("idle_id3_derr", {7'd0, dup_err}, 8'h01);
    check("idle_id3_vready", {7'd0, vote_ready}, 8'h01);
    check("idle_id3_wvalid", {7'd0, word_valid}, 8'h00);

    // Test 1: id0=1, id1=0, id2=1 -> 101
    send_vote(2'd0, 1'b1);
    check("t1_derr_clear", {7'd0, dup_err}, 8'h00);
    send_vote(2'd1, 1'b0);
    check("t1_wvalid_mid", {7'd0, word_valid}, 8'h00);
    send_vote(2'd2, 1'b1);
    check("t1_word", {5'd0, word_out}, 8'h05);
    check("t1_wvalid", {7'd0, word_valid}, 8'h01);
    check("t1_vready", {7'd0, vote_ready}, 8'h00);
    check("t1_terr", {7'd0, timeout_err}, 8'h00);
    check("t1_derr", {7'd0, dup_err}, 8'h00);
    tick();
    check("t1_wvalid_drop", {7'd0, word_valid}, 8'h00);
    check("t1_cnt", round_cnt, 8'd1);
    check("t1_vready_back", {7'd0, vote_ready}, 8'h01);

    // Test 2: id2=1, id0=1, id0=0 (duplicate), id1=1 -> 111
    send_vote(2'd2, 1'b1);
    send_vote(2'd0, 1'b1);
    send_vote(2'd0, 1'b0);
    check("t2_derr", {7'd0, dup_err}, 8'h01);
    check("t2_wvalid_mid", {7'd0, word_valid}, 8'h00);
    send_vote(2'd1, 1'b1);
    check("t2_derr_clear", {7'd0, dup_err}, 8'h00);
    check("t2_word", {5'd0, word_out}, 8'h07);
    check("t2_wvalid", {7'd0, word_valid}, 8'h01);
    tick();
    check("t2_cnt", round_cnt, 8'd2);

    // Test 3: single vote id1=1 then timeout after 15 COLLECT cycles -> 010
    send_vote(2'd1, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    check("t3_no_early_timeout", {7'd0, word_valid}, 8'h00);
    check("t3_no_early_terr", {7'd0, timeout_err}, 8'h00);
    tick();
    check("t3_terr", {7'd0, timeout_err}, 8'h01);
    check("t3_wvalid", {7'd0, word_valid}, 8'h01);
    check("t3_word", {5'd0, word_out}, 8'h02);
    tick();
    check("t3_terr_pulse", {7'd0, timeout_err}, 8'h00);
    check("t3_cnt", round_cnt, 8'd3);

    // Test 4: round 1,1,0 held by word_ready=0 for 5 cycles with extra votes
    word_ready = 1'b0;
    send_vote(2'd0, 1'b1);
    send_vote(2'd1, 1'b1);
    send_vote(2'd2, 1'b0);
    check("t4_word", {5'd0, word_out}, 8'h03);
    vote_valid = 1'b1;
    vote_id    = 2'd0;
    vote_bit   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_word", {5'd0, word_out}, 8'h03);
      check("t4_hold_wvalid", {7'd0, word_valid}, 8'h01);
      check("t4_hold_vready", {7'd0, vote_ready}, 8'h00);
      check("t4_hold_derr", {7'd0, dup_err}, 8'h00);
    end
    vote_valid = 1'b0;
    word_ready = 1'b1;
    tick();
    check("t4_wvalid_drop", {7'd0, word_valid}, 8'h00);
    check("t4_cnt", round_cnt, 8'd4);

    // Test 5: asynchronous reset after two votes, then a fresh round 1,1,0
    send_vote(2'd0, 1'b1);
    send_vote(2'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("t5_rst");
    tick();
    rst_n = 1'b1;
    send_vote(2'd0, 1'b1);
    send_vote(2'd1, 1'b1);
    send_vote(2'd2, 1'b0);
    check("t5_word", {5'd0, word_out}, 8'h03);
    check("t5_wvalid", {7'd0, word_valid}, 8'h01);
    tick();
    check("t5_cnt", round_cnt, 8'd1);

    // Test 6: 256 back-to-back rounds from reset, majority on every word
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < 256; r++) begin
      pat = 3'(r * 5 + 3);
      send_vote(2'd0, pat[0]);
      send_vote(2'd1, pat[1]);
      send_vote(2'd2, pat[2]);
      exp_maj = (int'(pat[0]) + int'(pat[1]) + int'(pat[2])) >= 2;
      dut_maj = (word_out[0] & word_out[1]) | (word_out[1] & word_out[2]) |
                (word_out[0] & word_out[2]);
      check("t6_word", {5'd0, word_out}, {5'd0, pat});
      check("t6_maj", {7'd0, dut_maj}, {7'd0, exp_maj});
      if (r == 255) check("t6_cnt_pre_wrap", round_cnt, 8'd255);
      tick();
    end
    check("t6_cnt_wrap", round_cnt, 8'd0);
    check("t6_idle_vready", {7'd0, vote_ready}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
